cu_command_arbiter: RTL and testbench
=====================================

// Module: cu_command_arbiter
// PURPOSE
//  Shares one CAPI command buffer port among NUM_REQUESTORS engines. Typical users are the
//  read/write engines of several CUs. Each requestor gets a one-entry holding slot. A
//  round-robin arbiter drains full slots into a registered CommandBufferLine output and
//  honours buffer almost-full backpressure. It sits between cu_control instances and the
//  afu command buffer.
// PARAMETERS
//  NUM_REQUESTORS  4  number of command sources, 2..16
//  ID_WIDTH        2  width of grant_id_out, must equal $clog2(NUM_REQUESTORS)
// PORTS
//  clock                 in   1                     single clock, rising edge
//  rst_in                in   1                     asynchronous, active-high reset
//  enabled_in            in   1                     global enable
//  command_buffer_status in   BufferStatus          uses only .alfull
//  command_in            in   CommandBufferLine[N]  per-requestor command (.valid/.payload)
//  command_ready_out     out  [N]                   slot i can accept a command
//  command_out           out  CommandBufferLine     arbitrated command to the buffer
//  grant_id_out          out  ID_WIDTH              index of the requestor behind command_out
// BEHAVIOUR
//  - Reset (async, rst_in=1): all slots empty; rr pointer=0; command_out.valid=0;
//    grant_id_out=0; command_ready_out=0 while rst_in=1.
//  - command_ready_out[i] = enabled_in & ~slot_full[i]. This is combinational from state only.
//    It has no path from command_in.
//  - Capture: command_in[i].valid & command_ready_out[i] at an edge. The payload is copied
//    and slot_full[i] is set. The requestor must not drop valid before the handshake.
//  - Arbitration each cycle when enabled_in & ~alfull & any slot_full:
//    - The winner is the first full slot at or after the rr pointer, modulo N.
//    - Next edge: command_out gets the slot payload with valid=1, grant_id_out gets the
//      winner index, slot_full[winner] is cleared, and rr pointer = (winner+1) mod N.
//      The pointer wraps N-1 -> 0.
//  - No winner, or alfull=1, or enabled_in=0: next edge sets command_out.valid=0.
//    Payload and grant_id_out hold. Slots and pointer hold.
//  - Latency: capture edge E. Earliest command_out.valid at edge E+1, from the state
//    latched at E. Under contention, at most N-1 other grants precede it.
//  - Per-requestor throughput is 1 command per 2 cycles, because a slot cannot refill on
//    the edge it drains. Aggregate throughput is 1 command/cycle with >=2 active requestors.
//  - Simultaneous capture in slot j and grant of slot k (j!=k) is legal.
//  - alfull asserted mid-stream: no command is dropped or duplicated. Full slots wait and
//    ready stays low for them.
//  - enabled_in deasserted mid-operation: state freezes. Pending slots resume in the
//    original RR order when it is reasserted.
//  - Reset mid-operation discards pending slot contents.
//  - command_out.payload needs no reset. The valid bit alone qualifies it.
// CONFIGURATION
//  CU_COMMAND_ARBITER_STATS_EN
//   - Defined: adds output grant_count_out [N][0:31]. Counter i increments on every grant
//     to requestor i, saturates at 32'hFFFF_FFFF, and resets to 0.
//   - Undefined: the port and counters are absent. Arbitration behaviour is identical.
// STRUCTURE
//  - Shared package (CU_PKG) holds:
//    - typedef arb_request_vector (logic [0:NUM_REQUESTORS-1]);
//    - localparam CU_ARB_NUM_REQUESTORS_MAX=16;
//    - the stats counter width constant.
//  - Sub-module round_robin_priority_arbiter (#NUM_REQUESTORS) is combinational.
//    - Inputs: request vector and rr pointer.
//    - Outputs: one-hot grant, encoded index and any_grant.
//  - The top holds slots, pointer, output register and optional counters.
// TESTING
//  1 Reset: assert rst_in mid-stream with slot 2 full -> command_out.valid=0, grant_id_out=0,
//    all ready=0; after release all ready=1 and slot 2 is gone.
//  2 Single requestor: req1 valid at every cycle, 8 commands tags 0..7 -> 8 outputs in order,
//    grant_id_out=1, one every 2 cycles.
//  3 Fairness: all 4 requestors continuously valid -> grant_id_out sequence 0,1,2,3,0,1,...
//    with valid=1 every cycle after the first.
//  4 Backpressure: alfull=1 for 10 cycles with 4 slots full -> valid=0 during the stall;
//    after release exactly 4 commands, no loss/duplicates, RR order preserved.
//  5 Wrap/skip: pointer=3, only slots 1 and 3 full -> grants 3 then 1, pointer ends at 2.
//  6 STATS_EN: 5 grants to req0 and 3 to req2 -> grant_count_out = {5,0,3,0}.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and constants for the CU command path.
//
// Contents:
//   CU_ARB_NUM_REQUESTORS_MAX  upper bound on arbiter requestors
//   CU_ARB_STATS_COUNT_WIDTH   width of per-requestor grant counters
//   CU_CMD_PAYLOAD_WIDTH       width of a command buffer payload
//   arb_request_vector         request vector sized for the largest arbiter
//   CommandBufferLine          valid-qualified command word
//   BufferStatus               command buffer fill status
package cu_pkg;

    localparam int unsigned CU_ARB_NUM_REQUESTORS_MAX = 16;
    localparam int unsigned CU_ARB_STATS_COUNT_WIDTH  = 32;
    localparam int unsigned CU_CMD_PAYLOAD_WIDTH      = 32;

    // Bit i is requestor i; narrower arbiters zero-pad the unused tail.
    typedef logic [0:CU_ARB_NUM_REQUESTORS_MAX-1] arb_request_vector;

    typedef struct packed {
        logic                            valid;
        logic [CU_CMD_PAYLOAD_WIDTH-1:0] payload;
    } CommandBufferLine;

    typedef struct packed {
        logic alfull;
        logic full;
        logic empty;
    } BufferStatus;

endpackage

// File: rtl/round_robin_priority_arbiter.sv
// Combinational round-robin priority arbiter.
//
// Picks the first asserted request at or after rr_pointer, wrapping modulo NUM_REQUESTORS.
//
// Ports:
//   request      in   [NUM_REQUESTORS]  pending requests
//   rr_pointer   in   [ID_WIDTH]        highest-priority index this cycle
//   grant        out  [NUM_REQUESTORS]  one-hot grant (all zero when no request)
//   grant_index  out  [ID_WIDTH]        encoded grant (0 when no request)
//   any_grant    out  1                 at least one request present
module round_robin_priority_arbiter
    import cu_pkg::*;
#(
    parameter int unsigned NUM_REQUESTORS = 4,
    parameter int unsigned ID_WIDTH       = 2
) (
    input  logic [NUM_REQUESTORS-1:0] request,
    input  logic [ID_WIDTH-1:0]       rr_pointer,
    output logic [NUM_REQUESTORS-1:0] grant,
    output logic [ID_WIDTH-1:0]       grant_index,
    output logic                      any_grant
);

    localparam int unsigned PAD_WIDTH = $clog2(CU_ARB_NUM_REQUESTORS_MAX);

    arb_request_vector    request_padded;
    logic [ID_WIDTH-1:0]  candidate;

    always_comb begin
        request_padded = '0;
        for (int unsigned i = 0; i < NUM_REQUESTORS; i++) begin
            request_padded[PAD_WIDTH'(i)] = request[ID_WIDTH'(i)];
        end

        grant       = '0;
        grant_index = '0;
        any_grant   = 1'b0;
        candidate   = '0;
        // Scan from the pointer outward; the first hit wins.
        for (int unsigned k = 0; k < NUM_REQUESTORS; k++) begin
            candidate = ID_WIDTH'((32'(rr_pointer) + k) % NUM_REQUESTORS);
            if (!any_grant && request_padded[PAD_WIDTH'(candidate)]) begin
                any_grant        = 1'b1;
                grant[candidate] = 1'b1;
                grant_index      = candidate;
            end
        end
    end

endmodule

// File: rtl/cu_command_arbiter.sv
// Shares one CAPI command buffer port among NUM_REQUESTORS engines.
//
// Each requestor owns a one-entry holding slot. A round-robin arbiter drains full slots
// into a registered command_out, stalling while the buffer reports almost-full or while
// enabled_in is low.
//
// Ports:
//   clock                  in   1                     rising-edge clock
//   rst_in                 in   1                     asynchronous active-high reset
//   enabled_in             in   1                     global enable; low freezes all state
//   command_buffer_status  in   BufferStatus          only .alfull is used
//   command_in             in   CommandBufferLine[N]  per-requestor command
//   command_ready_out      out  [N]                   slot i can accept a command
//   command_out            out  CommandBufferLine     arbitrated, registered command
//   grant_id_out           out  [ID_WIDTH]            requestor behind command_out
//   grant_count_out        out  [N][32]               grants per requestor (stats build only)
//
// Build option: define CU_COMMAND_ARBITER_STATS_EN to add saturating per-requestor grant
// counters and the grant_count_out port.
module cu_command_arbiter
    import cu_pkg::*;
#(
    parameter int unsigned NUM_REQUESTORS = 4,
    parameter int unsigned ID_WIDTH       = 2
) (
    input  logic                        clock,
    input  logic                        rst_in,
    input  logic                        enabled_in,
    input  BufferStatus                 command_buffer_status,
    input  CommandBufferLine            command_in [NUM_REQUESTORS],
    output logic [NUM_REQUESTORS-1:0]   command_ready_out,
    output CommandBufferLine            command_out,
    output logic [ID_WIDTH-1:0]         grant_id_out
`ifdef CU_COMMAND_ARBITER_STATS_EN
    ,
    output logic [CU_ARB_STATS_COUNT_WIDTH-1:0] grant_count_out [NUM_REQUESTORS]
`endif
);

    logic [NUM_REQUESTORS-1:0]       slot_full_q, slot_full_d;
    logic [CU_CMD_PAYLOAD_WIDTH-1:0] slot_payload_q [NUM_REQUESTORS];
    logic [NUM_REQUESTORS-1:0]       request_valid;
    logic [NUM_REQUESTORS-1:0]       capture;

    logic [ID_WIDTH-1:0]             rr_ptr_q, rr_ptr_d;
    logic [NUM_REQUESTORS-1:0]       arb_grant;
    logic [ID_WIDTH-1:0]             arb_index;
    logic                            arb_any;
    logic                            do_grant;

    logic                            out_valid_q;
    logic [CU_CMD_PAYLOAD_WIDTH-1:0] out_payload_q;
    logic [ID_WIDTH-1:0]             grant_id_q;

    logic                            unused_status;
    assign unused_status = ^{command_buffer_status.full, command_buffer_status.empty};

    // Ready depends on state only, so requestors may derive valid from ready freely.
    assign command_ready_out = {NUM_REQUESTORS{enabled_in & ~rst_in}} & ~slot_full_q;

    for (genvar i = 0; i < NUM_REQUESTORS; i++) begin : g_slot
        assign request_valid[i] = command_in[i].valid;

        always_ff @(posedge clock) begin
            if (capture[i]) begin
                slot_payload_q[i] <= command_in[i].payload;
            end
        end
    end

    assign capture = request_valid & command_ready_out;

    round_robin_priority_arbiter #(
        .NUM_REQUESTORS (NUM_REQUESTORS),
        .ID_WIDTH       (ID_WIDTH)
    ) u_rr_arbiter (
        .request     (slot_full_q),
        .rr_pointer  (rr_ptr_q),
        .grant       (arb_grant),
        .grant_index (arb_index),
        .any_grant   (arb_any)
    );

    assign do_grant = enabled_in & ~command_buffer_status.alfull & arb_any;

    always_comb begin
        // A slot being granted is full, so it can never be capturing on the same edge.
        slot_full_d = slot_full_q | capture;
        rr_ptr_d    = rr_ptr_q;
        if (do_grant) begin
            slot_full_d = slot_full_d & ~arb_grant;
            rr_ptr_d    = (arb_index == ID_WIDTH'(NUM_REQUESTORS - 1)) ? '0
                                                                       : arb_index + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            slot_full_q <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            grant_id_q  <= '0;
        end else begin
            slot_full_q <= slot_full_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= do_grant;
            if (do_grant) begin
                grant_id_q <= arb_index;
            end
        end
    end

    // Payload is qualified by out_valid_q, so it carries no reset.
    always_ff @(posedge clock) begin
        if (do_grant) begin
            out_payload_q <= slot_payload_q[arb_index];
        end
    end

    always_comb begin
        command_out         = '0;
        command_out.valid   = out_valid_q;
        command_out.payload = out_payload_q;
    end

    assign grant_id_out = grant_id_q;

`ifdef CU_COMMAND_ARBITER_STATS_EN
    logic [CU_ARB_STATS_COUNT_WIDTH-1:0] grant_count_q [NUM_REQUESTORS];

    for (genvar i = 0; i < NUM_REQUESTORS; i++) begin : g_stats
        always_ff @(posedge clock or posedge rst_in) begin
            if (rst_in) begin
                grant_count_q[i] <= '0;
            end else if (do_grant && arb_grant[i] && (grant_count_q[i] != '1)) begin
                grant_count_q[i] <= grant_count_q[i] + 1'b1;
            end
        end
        assign grant_count_out[i] = grant_count_q[i];
    end
`endif

endmodule

// File: tb/tb_cu_command_arbiter.sv
// Directed self-checking bench for cu_command_arbiter (4 requestors).
module tb_cu_command_arbiter;
    import cu_pkg::*;

    logic             clock;
    logic             rst_in;
    logic             enabled_in;
    BufferStatus      command_buffer_status;
    CommandBufferLine command_in [4];
    logic [3:0]       command_ready_out;
    CommandBufferLine command_out;
    logic [1:0]       grant_id_out;
`ifdef CU_COMMAND_ARBITER_STATS_EN
    logic [31:0]      grant_count_out [4];
`endif

    int tests;
    int fails;

    cu_command_arbiter #(
        .NUM_REQUESTORS (4),
        .ID_WIDTH       (2)
    ) dut (
        .clock                 (clock),
        .rst_in                (rst_in),
        .enabled_in            (enabled_in),
        .command_buffer_status (command_buffer_status),
        .command_in            (command_in),
        .command_ready_out     (command_ready_out),
        .command_out           (command_out),
        .grant_id_out          (grant_id_out)
`ifdef CU_COMMAND_ARBITER_STATS_EN
        ,
        .grant_count_out       (grant_count_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required to finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            command_in[i] = '0;
        end
        command_buffer_status = '0;
        enabled_in = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        #1;
    endtask

    // Hold valid on one requestor until the handshake edge, then drop it.
    task automatic send_one(input int idx, input logic [31:0] pl);
        logic rdy;
        bit   done;
        done = 1'b0;
        command_in[idx].valid   = 1'b1;
        command_in[idx].payload = pl;
        for (int n = 0; n < 20 && !done; n++) begin
            rdy = command_ready_out[idx];
            step();
            if (rdy) done = 1'b1;
        end
        command_in[idx].valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_one_timeout: req %0d no handshake, required within 20 cycles",
                     idx);
        end
    endtask

    task automatic test_reset_initial();
        step();
        tests++;
        if (command_out.valid !== 1'b0) begin
            fails++;
            $display("FAIL init_valid: got %b, required 0", command_out.valid);
        end
        tests++;
        if (grant_id_out !== 2'd0) begin
            fails++;
            $display("FAIL init_grant_id: got %0d, required 0", grant_id_out);
        end
        tests++;
        if (command_ready_out !== 4'b0000) begin
            fails++;
            $display("FAIL init_ready_in_reset: got %b, required 0000", command_ready_out);
        end
        rst_in = 1'b0;
        #1;
        tests++;
        if (command_ready_out !== 4'b1111) begin
            fails++;
            $display("FAIL init_ready_after: got %b, required 1111", command_ready_out);
        end
    endtask

    task automatic test_reset();
        do_reset();
        send_one(3, 32'h0000_0033);
        step();
        tests++;
        if (command_out.valid !== 1'b1 || grant_id_out !== 2'd3) begin
            fails++;
            $display("FAIL rst_pre_grant: got valid %b id %0d, required valid 1 id 3",
                     command_out.valid, grant_id_out);
        end
        command_buffer_status.alfull = 1'b1;
        send_one(2, 32'h0000_0022);
        tests++;
        if (command_ready_out !== 4'b1011) begin
            fails++;
            $display("FAIL rst_slot2_full: ready got %b, required 1011", command_ready_out);
        end
        rst_in = 1'b1;
        #1;
        tests++;
        if (command_out.valid !== 1'b0 || grant_id_out !== 2'd0 ||
            command_ready_out !== 4'b0000) begin
            fails++;
            $display("FAIL rst_async: got valid %b id %0d ready %b, required 0 0 0000",
                     command_out.valid, grant_id_out, command_ready_out);
        end
        step();
        rst_in = 1'b0;
        command_buffer_status.alfull = 1'b0;
        #1;
        tests++;
        if (command_ready_out !== 4'b1111) begin
            fails++;
            $display("FAIL rst_release_ready: got %b, required 1111", command_ready_out);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if (command_out.valid !== 1'b0) begin
                fails++;
                $display("FAIL rst_slot_discarded[%0d]: valid got %b, required 0",
                         c, command_out.valid);
            end
        end
    endtask

    task automatic test_single();
        int   tag;
        int   got;
        int   cyc;
        int   prev;
        logic rdy;
        do_reset();
        tag = 0;
        got = 0;
        cyc = 0;
        prev = 0;
        command_in[1].valid   = 1'b1;
        command_in[1].payload = 32'h100;
        while (got < 8 && cyc < 40) begin
            rdy = command_ready_out[1];
            step();
            cyc++;
            if (rdy && command_in[1].valid) begin
                tag++;
                if (tag < 8) command_in[1].payload = 32'(32'h100 + tag);
                else command_in[1].valid = 1'b0;
            end
            if (command_out.valid) begin
                tests++;
                if (command_out.payload !== 32'(32'h100 + got)) begin
                    fails++;
                    $display("FAIL single_payload[%0d]: got %h, required %h",
                             got, command_out.payload, 32'(32'h100 + got));
                end
                tests++;
                if (grant_id_out !== 2'd1) begin
                    fails++;
                    $display("FAIL single_id[%0d]: got %0d, required 1", got, grant_id_out);
                end
                if (got > 0) begin
                    tests++;
                    if (cyc - prev != 2) begin
                        fails++;
                        $display("FAIL single_spacing[%0d]: got %0d cycles, required 2",
                                 got, cyc - prev);
                    end
                end
                prev = cyc;
                got++;
            end
        end
        command_in[1].valid = 1'b0;
        tests++;
        if (got != 8) begin
            fails++;
            $display("FAIL single_count: got %0d outputs, required 8", got);
        end
    endtask

    task automatic test_fairness();
        int         seq [4];
        int         out_seq [4];
        int         got;
        int         cyc;
        int         prev;
        logic [3:0] rdy;
        logic [1:0] exp_id;
        do_reset();
        got = 0;
        cyc = 0;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            out_seq[i] = 0;
            command_in[i].valid   = 1'b1;
            command_in[i].payload = 32'(i << 8);
        end
        while (got < 12 && cyc < 40) begin
            rdy = command_ready_out;
            step();
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (rdy[i]) begin
                    seq[i]++;
                    command_in[i].payload = 32'((i << 8) | seq[i]);
                end
            end
            if (command_out.valid) begin
                exp_id = 2'(got % 4);
                tests++;
                if (grant_id_out !== exp_id) begin
                    fails++;
                    $display("FAIL fair_id[%0d]: got %0d, required %0d", got, grant_id_out,
                             exp_id);
                end
                tests++;
                if (command_out.payload !== 32'((int'(exp_id) << 8) | out_seq[exp_id])) begin
                    fails++;
                    $display("FAIL fair_payload[%0d]: got %h, required %h", got,
                             command_out.payload, 32'((int'(exp_id) << 8) | out_seq[exp_id]));
                end
                out_seq[exp_id]++;
                if (got > 0) begin
                    tests++;
                    if (cyc != prev + 1) begin
                        fails++;
                        $display("FAIL fair_back_to_back[%0d]: gap %0d cycles, required 1",
                                 got, cyc - prev);
                    end
                end
                prev = cyc;
                got++;
            end
        end
        for (int i = 0; i < 4; i++) command_in[i].valid = 1'b0;
        tests++;
        if (got != 12) begin
            fails++;
            $display("FAIL fair_count: got %0d outputs, required 12", got);
        end
    endtask

    task automatic test_backpressure();
        int got;
        do_reset();
        command_buffer_status.alfull = 1'b1;
        for (int i = 0; i < 4; i++) send_one(i, 32'(32'hA0 + i));
        for (int c = 0; c < 10; c++) begin
            step();
            tests++;
            if (command_out.valid !== 1'b0) begin
                fails++;
                $display("FAIL bp_stall_valid[%0d]: got %b, required 0", c, command_out.valid);
            end
        end
        tests++;
        if (command_ready_out !== 4'b0000) begin
            fails++;
            $display("FAIL bp_stall_ready: got %b, required 0000", command_ready_out);
        end
        command_buffer_status.alfull = 1'b0;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (command_out.valid) begin
                if (got < 4) begin
                    tests++;
                    if (grant_id_out !== 2'(got) ||
                        command_out.payload !== 32'(32'hA0 + got)) begin
                        fails++;
                        $display("FAIL bp_drain[%0d]: got id %0d data %h, required id %0d data %h",
                                 got, grant_id_out, command_out.payload, got,
                                 32'(32'hA0 + got));
                    end
                end
                got++;
            end
        end
        tests++;
        if (got != 4) begin
            fails++;
            $display("FAIL bp_count: got %0d outputs, required 4", got);
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        send_one(2, 32'h0000_0002);
        step();
        command_buffer_status.alfull = 1'b1;
        send_one(1, 32'h0000_0011);
        send_one(3, 32'h0000_0033);
        command_buffer_status.alfull = 1'b0;
        step();
        tests++;
        if (command_out.valid !== 1'b1 || grant_id_out !== 2'd3 ||
            command_out.payload !== 32'h33) begin
            fails++;
            $display("FAIL wrap_first: got v%b id %0d data %h, required v1 id 3 data 33",
                     command_out.valid, grant_id_out, command_out.payload);
        end
        step();
        tests++;
        if (command_out.valid !== 1'b1 || grant_id_out !== 2'd1 ||
            command_out.payload !== 32'h11) begin
            fails++;
            $display("FAIL wrap_second: got v%b id %0d data %h, required v1 id 1 data 11",
                     command_out.valid, grant_id_out, command_out.payload);
        end
        step();
        tests++;
        if (command_out.valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_idle: valid got %b, required 0", command_out.valid);
        end
        // Pointer should now be 2: with slots 1 and 2 full, slot 2 must win first.
        command_buffer_status.alfull = 1'b1;
        send_one(1, 32'h0000_0111);
        send_one(2, 32'h0000_0222);
        command_buffer_status.alfull = 1'b0;
        step();
        tests++;
        if (grant_id_out !== 2'd2 || command_out.valid !== 1'b1) begin
            fails++;
            $display("FAIL wrap_ptr_end: got v%b id %0d, required v1 id 2",
                     command_out.valid, grant_id_out);
        end
        step();
        tests++;
        if (grant_id_out !== 2'd1 || command_out.valid !== 1'b1) begin
            fails++;
            $display("FAIL wrap_ptr_next: got v%b id %0d, required v1 id 1",
                     command_out.valid, grant_id_out);
        end
    endtask

    task automatic test_enable_freeze();
        do_reset();
        command_buffer_status.alfull = 1'b1;
        for (int i = 0; i < 3; i++) send_one(i, 32'(32'hE0 + i));
        command_buffer_status.alfull = 1'b0;
        step();
        enabled_in = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if (command_out.valid !== 1'b0 || command_ready_out !== 4'b0000) begin
                fails++;
                $display("FAIL en_freeze[%0d]: got valid %b ready %b, required 0 0000",
                         c, command_out.valid, command_ready_out);
            end
        end
        enabled_in = 1'b1;
        for (int k = 1; k < 3; k++) begin
            step();
            tests++;
            if (command_out.valid !== 1'b1 || grant_id_out !== 2'(k) ||
                command_out.payload !== 32'(32'hE0 + k)) begin
                fails++;
                $display("FAIL en_resume[%0d]: got v%b id %0d data %h, required v1 id %0d data %h",
                         k, command_out.valid, grant_id_out, command_out.payload, k,
                         32'(32'hE0 + k));
            end
        end
    endtask

`ifdef CU_COMMAND_ARBITER_STATS_EN
    task automatic test_stats();
        logic [31:0] exp_cnt [4];
        exp_cnt[0] = 32'd5;
        exp_cnt[1] = 32'd0;
        exp_cnt[2] = 32'd3;
        exp_cnt[3] = 32'd0;
        do_reset();
        for (int n = 0; n < 5; n++) send_one(0, 32'(n));
        for (int n = 0; n < 3; n++) send_one(2, 32'(n));
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (grant_count_out[i] !== exp_cnt[i]) begin
                fails++;
                $display("FAIL stats_count[%0d]: got %0d, required %0d", i,
                         grant_count_out[i], exp_cnt[i]);
            end
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        clear_inputs();
        rst_in = 1'b1;
        test_reset_initial();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap_skip();
        test_enable_freeze();
`ifdef CU_COMMAND_ARBITER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
